// File: rtl/lut_neuron_pkg.sv
// Shared types and size helpers for the runtime-loadable truth-table neuron.
package lut_neuron_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    READY
  } state_e;

  function automatic int tbl_bits_f(input int in_bits, input int out_bits);
    return (1 << in_bits) * out_bits;
  endfunction

  function automatic int beats_f(input int in_bits, input int out_bits, input int cfg_w);
    return tbl_bits_f(in_bits, out_bits) / cfg_w;
  endfunction

  function automatic int cnt_w_f(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int TBL_BITS = tbl_bits_f(8, 1);
  localparam int BEATS    = beats_f(8, 1, 8);

endpackage

// File: rtl/lut_tbl_ram.sv
// Truth-table storage: CFG_W-bit write port indexed by beat, OUT_BITS-bit
// registered read port indexed by lookup address.
module lut_tbl_ram
  import lut_neuron_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1,
  parameter int CFG_W    = 8
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic                                                    we_i,
  input  logic [cnt_w_f(beats_f(IN_BITS, OUT_BITS, CFG_W))-1:0]   waddr_i,
  input  logic [CFG_W-1:0]                                        wdata_i,
  input  logic                                                    re_i,
  input  logic [IN_BITS-1:0]                                      raddr_i,
  output logic [OUT_BITS-1:0]                                     rdata_o
);

  localparam int TBL_BITS = tbl_bits_f(IN_BITS, OUT_BITS);
  localparam int BIT_AW   = (TBL_BITS > 1) ? $clog2(TBL_BITS) : 1;

  (* ram_style = "distributed" *) logic [TBL_BITS-1:0] mem_q;
  logic [OUT_BITS-1:0] rdata_q;
  logic [BIT_AW-1:0]   wbase;
  logic [BIT_AW-1:0]   rbase;

  assign wbase = BIT_AW'(waddr_i) * BIT_AW'(CFG_W);
  assign rbase = BIT_AW'(raddr_i) * BIT_AW'(OUT_BITS);

  // Storage is intentionally unreset; contents only matter once a load completes.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wbase +: CFG_W] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[rbase +: OUT_BITS];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lut_neuron_loader.sv
// Runtime-programmable truth-table neuron: config-stream loader plus lookup stream.
// Optional config parity check enabled by defining LUT_CFG_PARITY_EN.
module lut_neuron_loader
  import lut_neuron_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1,
  parameter int CFG_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CFG_W-1:0]    cfg_data,
  input  logic                cfg_last,
`ifdef LUT_CFG_PARITY_EN
  input  logic                cfg_par,
`endif
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data,
  output logic                loaded,
  output logic                cfg_err
);

  localparam int BEATS = beats_f(IN_BITS, OUT_BITS, CFG_W);
  localparam int CNT_W = cnt_w_f(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             cfg_err_q, cfg_err_d;
  logic             out_valid_q, out_valid_d;
  logic             cfg_acc, in_acc, first_beat, par_err;
  logic [CNT_W-1:0] waddr;

`ifdef LUT_CFG_PARITY_EN
  assign par_err = cfg_par ^ (^cfg_data);
`else
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      beat_cnt_q  <= '0;
      cfg_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      cfg_err_q   <= cfg_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    cfg_err_d   = cfg_err_q;
    out_valid_d = out_valid_q;
    cfg_ready   = 1'b0;
    in_ready    = 1'b0;
    first_beat  = 1'b0;
    waddr       = beat_cnt_q;

    case (state_q)
      EMPTY: begin
        cfg_ready  = 1'b1;
        first_beat = 1'b1;
      end
      LOAD: cfg_ready = 1'b1;
      READY: begin
        // A pending result blocks config so the table never changes under it;
        // config also has priority over a simultaneous lookup.
        cfg_ready  = !out_valid_q;
        in_ready   = !cfg_valid && (!out_valid_q || out_ready);
        first_beat = 1'b1;
      end
      default: ;
    endcase

    if (first_beat) waddr = '0;
    cfg_acc = cfg_valid && cfg_ready;
    in_acc  = in_valid && in_ready;

    if (in_acc)         out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;

    if (cfg_acc) begin
      if (first_beat) cfg_err_d = 1'b0;
      // Framing error: last flag must coincide exactly with the terminal beat.
      if (par_err || (cfg_last != (waddr == LAST_BEAT))) begin
        state_d    = EMPTY;
        cfg_err_d  = 1'b1;
        beat_cnt_d = '0;
      end else if (cfg_last) begin
        state_d    = READY;
        beat_cnt_d = '0;
      end else begin
        state_d    = LOAD;
        beat_cnt_d = waddr + CNT_W'(1);
      end
    end
  end

  lut_tbl_ram #(
    .IN_BITS (IN_BITS),
    .OUT_BITS(OUT_BITS),
    .CFG_W   (CFG_W)
  ) u_tbl (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (cfg_acc),
    .waddr_i(waddr),
    .wdata_i(cfg_data),
    .re_i   (in_acc),
    .raddr_i(in_data),
    .rdata_o(out_data)
  );

  assign loaded    = (state_q == READY);
  assign cfg_err   = cfg_err_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/lut_neuron_loader.md
Name: lut_neuron_loader

Overview:
Runtime-programmable truth-table neuron. A config stream writes the 2^IN_BITS x OUT_BITS table, one CFG_W-bit beat at a time. Once the table is complete, the block serves lookups over a valid/ready stream with a registered output. It is the writer/loader counterpart to the fixed-ROM layer neurons, and lets a layer's tables be reloaded without resynthesis.

Parameters:
IN_BITS, 8, lookup address width; table depth = 2^IN_BITS entries.
OUT_BITS, 1, bits per table entry.
CFG_W, 8, config beat width; must divide 2^IN_BITS*OUT_BITS.
(Derived: TBL_BITS = 2^IN_BITS*OUT_BITS; BEATS = TBL_BITS/CFG_W, which is 32 at defaults.)

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cfg_valid  in  1  config beat valid.
cfg_ready  out  1  config beat accepted when cfg_valid&cfg_ready.
cfg_data  in  CFG_W  table bits; bit j of beat k -> table bit k*CFG_W+j.
cfg_last  in  1  marks the final beat of a load.
in_valid  in  1  lookup request valid.
in_ready  out  1  lookup accepted when in_valid&in_ready.
in_data  in  IN_BITS  lookup address.
out_valid  out  1  lookup result valid.
out_ready  in  1  downstream accepts result.
out_data  out  OUT_BITS  table bits [addr*OUT_BITS +: OUT_BITS].
loaded  out  1  high in state READY.
cfg_err  out  1  sticky load-framing error; cleared on the next accepted first beat.

Behaviour:
- Reset values: state=EMPTY, beat_cnt=0, loaded=0, cfg_err=0, out_valid=0, out_data=0.
- Table storage has no reset; its contents are don't-care until READY.
- States:
  - EMPTY: cfg_ready=1, in_ready=0. Accepted beat -> LOAD, or -> READY if BEATS==1 and cfg_last.
  - LOAD: cfg_ready=1, in_ready=0. Each accepted beat writes its CFG_W bits and increments beat_cnt.
  - READY: in_ready = !out_valid | out_ready. cfg_ready = !out_valid. An accepted beat starts a reload: loaded drops the next cycle and the state goes to LOAD.
- First beat: any beat accepted in EMPTY, or in READY, resets beat_cnt to 0 before writing and clears cfg_err.
- Framing rules:
  - Beat BEATS-1 with cfg_last=1 -> READY, beat_cnt=0.
  - cfg_last=1 on an earlier beat -> cfg_err=1, state EMPTY.
  - Beat BEATS-1 with cfg_last=0 -> cfg_err=1, state EMPTY.
  - Erroneous beats are still written; their content is irrelevant because loaded stays 0.
- Lookup: 1-cycle latency. An accepted in_data produces the registered out_data with out_valid=1 in the next cycle. The result holds while out_valid & !out_ready. Full throughput is 1 lookup/cycle when out_ready=1.
- A result remains pending in READY even while a new config beat is offered; the config beat waits on cfg_ready. The table is never written while a result is pending.
- Simultaneous cfg_valid and in_valid in READY with out_valid=0: config wins. in_ready is forced to 0 in that cycle, so in_ready = READY & !cfg_valid & (!out_valid|out_ready).
- Async reset mid-load or mid-lookup: everything returns to reset values immediately. The partial table is discarded logically (loaded=0).
- Arithmetic: beat_cnt width is clog2(BEATS) (min 1). Compare-to-last is exact; no wrap occurs because the terminal beat always exits LOAD.

Optional Feature:
LUT_CFG_PARITY_EN:
- Defined: adds input port cfg_par (1 bit), which must equal the XOR of cfg_data. A mismatch on any accepted beat sets cfg_err and forces the state to EMPTY at that beat.
- Undefined: no cfg_par port and no parity check.

Decomposition:
- Package lut_neuron_pkg holds the state enum (EMPTY, LOAD, READY), the derived-width function for beat_cnt, and the localparam TBL_BITS/BEATS computations.
- Sub-module lut_tbl_ram: a simple dual-port table with a CFG_W-bit write port (addr=beat index) and an OUT_BITS-bit registered read port. It carries the distributed-RAM style attribute.
- The top level holds the FSM, counters and handshakes.

Test Plan:
1. Reset, then cfg_data=8'hA5 on all 32 beats with cfg_last on beat 31 -> loaded=1 one cycle after the last beat. Lookups 0,1,2,7 -> out_data 1,0,1,1, each one cycle after acceptance.
2. in_valid=1 while EMPTY or LOAD -> in_ready=0 and out_valid never asserts.
3. cfg_last on beat 10 -> cfg_err=1, loaded=0, state EMPTY. A following clean 32-beat load of 8'hFF clears cfg_err and makes lookup 255 return 1.
4. out_ready held 0 for 5 cycles after a lookup -> out_data stable and in_ready=0. cfg_valid offered in the same window -> cfg_ready=0 until the result drains.
5. cfg_valid and in_valid asserted together in READY -> config beat accepted, lookup stalled, loaded falls next cycle. Reload of 8'h00 completes and lookup 0 returns 0.
6. rst_n pulsed low at beat 16 of a load -> outputs return to reset values asynchronously. A fresh load then completes normally. With LUT_CFG_PARITY_EN, a wrong cfg_par on beat 3 sets cfg_err.
